// File: rtl/irq_arbiter_if.sv
// Bundle of the interrupt arbiter's peripheral-side and core-side signals.
// The slave modport is the arbiter itself; the master modport is the core/peripheral side.
interface irq_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2
);
    logic [NUM_SRC-1:0] irq_src;
    logic               kernel_mode;
    logic               ack;
    logic               eret;
    logic               mask_wr;
    logic [NUM_SRC-1:0] mask_din;
    logic               IRQ;
    logic [ID_W-1:0]    irq_id;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] pending;

    modport slave (
        input  irq_src, kernel_mode, ack, eret, mask_wr, mask_din,
        output IRQ, irq_id, mask, pending
    );

    modport master (
        output irq_src, kernel_mode, ack, eret, mask_wr, mask_din,
        input  IRQ, irq_id, mask, pending
    );
endinterface

// File: rtl/irq_arbiter.sv
// Edge-latching, maskable, fixed-priority interrupt arbiter feeding the decoder's IRQ input.
// One interrupt in service at a time; the handler's eret reopens arbitration.
module irq_arbiter #(
    parameter int                 NUM_SRC  = 4,
    parameter int                 ID_W     = 2,
    parameter logic [NUM_SRC-1:0] MASK_RST = {NUM_SRC{1'b1}}
) (
    input  logic         clk,
    input  logic         reset,
    irq_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] pending, pending_n;
    logic [NUM_SRC-1:0] mask;
    logic [ID_W-1:0]    irq_id, irq_id_n;

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] id_onehot;
    logic [NUM_SRC-1:0] clr;
    logic [ID_W-1:0]    winner;
    logic               id_enabled;
    logic               irq;
    logic               take;

    always_comb begin
        rise      = bus.irq_src & ~src_q;
        eligible  = pending & mask;
        winner    = '0;
        id_onehot = '0;
        // Scanning downward leaves the lowest set index as the winner.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) winner = ID_W'(i);
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (irq_id == ID_W'(i)) id_onehot[i] = 1'b1;
        end
        id_enabled = |(id_onehot & mask);
        irq        = (state == REQ) && !bus.kernel_mode;
        take       = irq && bus.ack;
        clr        = take ? id_onehot : '0;
        // A fresh edge on the acknowledged source re-arms it rather than being lost.
        pending_n  = (pending & ~clr) | rise;

        state_n  = state;
        irq_id_n = irq_id;
        case (state)
            IDLE: begin
                if ((|eligible) && !bus.kernel_mode) begin
                    state_n  = REQ;
                    irq_id_n = winner;
                end
            end
            REQ: begin
                if (take)             state_n = SERVICE;
                else if (!id_enabled) state_n = IDLE;
            end
            SERVICE: begin
                if (bus.eret) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            src_q   <= bus.irq_src;
            pending <= '0;
            mask    <= MASK_RST;
            irq_id  <= '0;
        end else begin
            state   <= state_n;
            src_q   <= bus.irq_src;
            pending <= pending_n;
            irq_id  <= irq_id_n;
            if (bus.mask_wr) mask <= bus.mask_din;
        end
    end

    assign bus.IRQ     = irq;
    assign bus.irq_id  = irq_id;
    assign bus.mask    = mask;
    assign bus.pending = pending;
endmodule

// File: tb/tb_irq_arbiter.sv
// Scoreboard bench for irq_arbiter: directed scenarios then random traffic, each cycle
// checked against a behavioural model of the interrupt rules.
module tb_irq_arbiter;
    logic clk;
    logic reset;

    irq_arbiter_if #(.NUM_SRC(4), .ID_W(2)) bus ();

    irq_arbiter #(.NUM_SRC(4), .ID_W(2), .MASK_RST(4'hF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       irq;
        logic [1:0] id;
        logic [3:0] mask;
        logic [3:0] pend;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Inputs currently applied to the DUT
    logic       cur_rst, cur_km, cur_ack, cur_eret, cur_mwr;
    logic [3:0] cur_src, cur_mdin;

    // Reference model state
    logic [3:0] m_pend, m_mask, m_prev;
    bit         m_asking, m_serving;
    int         m_id;

    task automatic model_step();
        bit took;
        int best;
        if (cur_rst) begin
            m_pend    = 4'h0;
            m_mask    = 4'hF;
            m_prev    = cur_src;
            m_asking  = 0;
            m_serving = 0;
            m_id      = 0;
        end else begin
            took = m_asking && cur_ack && !cur_km;
            best = -1;
            for (int i = 3; i >= 0; i--)
                if (m_pend[i] && m_mask[i]) best = i;
            if (m_asking) begin
                if (took) begin
                    m_asking  = 0;
                    m_serving = 1;
                end else if (!m_mask[m_id]) begin
                    m_asking = 0;
                end
            end else if (m_serving) begin
                if (cur_eret) m_serving = 0;
            end else if (best >= 0 && !cur_km) begin
                m_asking = 1;
                m_id     = best;
            end
            if (took) m_pend[m_id] = 1'b0;
            for (int i = 0; i < 4; i++)
                if (cur_src[i] && !m_prev[i]) m_pend[i] = 1'b1;
            if (cur_mwr) m_mask = cur_mdin;
            m_prev = cur_src;
        end
    endtask

    task automatic drive();
        reset           = cur_rst;
        bus.irq_src     = cur_src;
        bus.kernel_mode = cur_km;
        bus.ack         = cur_ack;
        bus.eret        = cur_eret;
        bus.mask_wr     = cur_mwr;
        bus.mask_din    = cur_mdin;
    endtask

    // One clock: retire the inputs seen at this edge, apply new ones, queue the expected view.
    task automatic applyStimulus(input logic rst, input logic [3:0] src, input logic km,
                                 input logic ack, input logic eret, input logic mwr,
                                 input logic [3:0] mdin);
        exp_t e;
        @(posedge clk);
        #1;
        model_step();
        cur_rst  = rst;
        cur_src  = src;
        cur_km   = km;
        cur_ack  = ack;
        cur_eret = eret;
        cur_mwr  = mwr;
        cur_mdin = mdin;
        drive();
        e.irq  = m_asking && !cur_km;
        e.id   = 2'(m_id);
        e.mask = m_mask;
        e.pend = m_pend;
        sb.push_back(e);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, cur_src, cur_km, 1'b0, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("IRQ",     {3'b0, bus.IRQ},    {3'b0, e.irq});
                checkOutput("irq_id",  {2'b0, bus.irq_id}, {2'b0, e.id});
                checkOutput("mask",    bus.mask,           e.mask);
                checkOutput("pending", bus.pending,        e.pend);
            end
        end
    end

    initial begin
        logic [3:0] src;
        cur_rst = 1'b1; cur_src = 4'b0010; cur_km = 1'b0; cur_ack = 1'b0;
        cur_eret = 1'b0; cur_mwr = 1'b0; cur_mdin = 4'h0;
        drive();

        // Reset with a line already high: no edge on release
        applyStimulus(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        applyStimulus(1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        hold(10);

        // Single source: request, ack, eret
        applyStimulus(1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        hold(3);
        applyStimulus(1'b0, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        hold(4);
        applyStimulus(1'b0, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        hold(3);

        // Two simultaneous edges: lower index first
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        applyStimulus(1'b0, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        hold(3);
        applyStimulus(1'b0, 4'b1010, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        hold(2);
        applyStimulus(1'b0, 4'b1010, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        hold(3);
        applyStimulus(1'b0, 4'b1010, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        applyStimulus(1'b0, 4'b1010, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        hold(2);

        // Masked edge, unmask, then withdraw by re-masking while requesting
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1110);
        applyStimulus(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        hold(3);
        applyStimulus(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1111);
        hold(3);
        applyStimulus(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1110);
        hold(3);
        applyStimulus(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1111);
        hold(2);

        // Kernel mode suppresses IRQ and ack while requesting
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        applyStimulus(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        applyStimulus(1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        hold(1);

        // Reset in service with a pending edge
        applyStimulus(1'b0, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        hold(2);
        applyStimulus(1'b1, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

        // Edge and ack for the same source in the same cycle
        applyStimulus(1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        hold(3);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        applyStimulus(1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        hold(3);
        applyStimulus(1'b0, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        hold(3);

        // Random traffic
        src = 4'h0;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(5) == 0) src[b] = ~src[b];
            applyStimulus(($urandom_range(399) == 0), src,
                          ($urandom_range(7) == 0), ($urandom_range(2) == 0),
                          ($urandom_range(4) == 0), ($urandom_range(15) == 0),
                          4'($urandom_range(15)));
        end
        hold(2);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
